router_fsm: RTL and testbench

- Packet-sequencing controller for the 1x3 router.
- Walks each incoming packet through header decode, payload load, FIFO-full stall, parity load and parity check.
- Drives the strobes that the register block and the write-enable/soft-reset synchronizer consume.
- Holds a packet in a wait state while its destination FIFO is non-empty; aborts to decode on that port's soft reset.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_fsm.sv | 137 +++++++++++++
 tb/tb_router_fsm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types for the 1x3 router: packet-sequencer state encoding and port address constants.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

    localparam logic [1:0] ADDR_P0      = 2'd0;
    localparam logic [1:0] ADDR_P1      = 2'd1;
    localparam logic [1:0] ADDR_P2      = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router (Moore FSM, outputs decoded from state).
// Optional ROUTER_FSM_DROP_CNT_EN adds a saturating count of soft-reset aborts taken mid-packet.
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
`ifdef ROUTER_FSM_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    router_state_t     state;
    router_state_t     next_state;
    logic [ADDR_W-1:0] addr;
    logic              addr_empty;
    logic              soft_abort;
    logic              data_empty;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
            addr  <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr <= data_in;
        end
    end

    // Per-port selects: the latched address picks the relevant empty flag and soft reset.
    always_comb begin
        addr_empty = 1'b0;
        soft_abort = 1'b0;
        case (addr)
            ADDR_P0: begin addr_empty = fifo_empty_0; soft_abort = soft_reset_0; end
            ADDR_P1: begin addr_empty = fifo_empty_1; soft_abort = soft_reset_1; end
            ADDR_P2: begin addr_empty = fifo_empty_2; soft_abort = soft_reset_2; end
            default: begin addr_empty = 1'b0;         soft_abort = 1'b0;         end
        endcase
    end

    always_comb begin
        data_empty = 1'b0;
        case (data_in)
            ADDR_P0: data_empty = fifo_empty_0;
            ADDR_P1: data_empty = fifo_empty_1;
            ADDR_P2: data_empty = fifo_empty_2;
            default: data_empty = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        if (soft_abort) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != ADDR_INVALID)
                        next_state = data_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        next_state = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        next_state = LOAD_PARITY;
                    else
                        next_state = LOAD_DATA;
                end
                LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (addr_empty)
                        next_state = LOAD_FIRST_DATA;
                end
                default: next_state = DECODE_ADDRESS;
            endcase
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

`ifdef ROUTER_FSM_DROP_CNT_EN
    // Aborts while already decoding drop nothing, so they are not counted.
    always_ff @(posedge clock) begin
        if (!resetn)
            drop_cnt <= 8'd0;
        else if (soft_abort && state != DECODE_ADDRESS && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: expected strobes per cycle are queued as stimulus is driven.
// Define ROUTER_FSM_DROP_CNT_EN to also check the abort counter.
module tb_router_fsm;
    import router_pkg::*;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
`ifdef ROUTER_FSM_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int         num_checks = 0;
    int         num_fails  = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] exp_drop = 8'd0;
    logic [7:0] drop_q[$];

    router_fsm #(.ADDR_W(2)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
`ifdef ROUTER_FSM_DROP_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected strobe vector {detect_add,lfd,ld,laf,full,write_enb,rst_int,busy}.
    function automatic logic [7:0] expOuts(input router_state_t s);
        case (s)
            DECODE_ADDRESS:     return 8'b1000_0000;
            LOAD_FIRST_DATA:    return 8'b0100_0001;
            LOAD_DATA:          return 8'b0010_0100;
            LOAD_AFTER_FULL:    return 8'b0001_0101;
            FIFO_FULL_STATE:    return 8'b0000_1001;
            LOAD_PARITY:        return 8'b0000_0101;
            CHECK_PARITY_ERROR: return 8'b0000_0011;
            default:            return 8'b0000_0001;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Queue the expectation for the current inputs, clock once, then pop and compare.
    task automatic applyStimulus(input router_state_t exp_state, input string tag);
        logic [7:0] e;
        string      t;
        logic [7:0] d;
        exp_q.push_back(expOuts(exp_state));
        tag_q.push_back(tag);
        drop_q.push_back(exp_drop);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        d = drop_q.pop_front();
        checkOutput(t, {detect_add, lfd_state, ld_state, laf_state, full_state,
                        write_enb_reg, rst_int_reg, busy}, e);
`ifdef ROUTER_FSM_DROP_CNT_EN
        checkOutput({t, "_drop"}, drop_cnt, d);
`else
        if (d != exp_drop) $display("[TB] note: drop expectation unused");
`endif
    endtask

    task automatic startPacket(input logic [1:0] port);
        pkt_valid = 1'b1;
        data_in   = port;
        applyStimulus(LOAD_FIRST_DATA, "pkt_lfd");
        applyStimulus(LOAD_DATA, "pkt_ld");
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
        parity_done = 1'b0; low_pkt_valid = 1'b0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        @(posedge clock); #1;

        applyStimulus(DECODE_ADDRESS, "reset0");
        applyStimulus(DECODE_ADDRESS, "reset1");
        resetn = 1'b1;
        applyStimulus(DECODE_ADDRESS, "idle0");
        applyStimulus(DECODE_ADDRESS, "idle1");

        // Normal packet to port 1
        pkt_valid = 1'b1; data_in = 2'd1;
        applyStimulus(LOAD_FIRST_DATA, "p1_lfd");
        applyStimulus(LOAD_DATA, "p1_ld0");
        applyStimulus(LOAD_DATA, "p1_ld1");
        applyStimulus(LOAD_DATA, "p1_ld2");
        pkt_valid = 1'b0;
        applyStimulus(LOAD_PARITY, "p1_lp");
        applyStimulus(CHECK_PARITY_ERROR, "p1_cpe");
        applyStimulus(DECODE_ADDRESS, "p1_done");

        // Full stall, exit through low_pkt_valid
        startPacket(2'd1);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(FIFO_FULL_STATE, "stall_full");
        fifo_full = 1'b0;
        applyStimulus(LOAD_AFTER_FULL, "stall_laf");
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        applyStimulus(LOAD_PARITY, "stall_lpv");
        low_pkt_valid = 1'b0;
        applyStimulus(CHECK_PARITY_ERROR, "stall_cpe");
        applyStimulus(DECODE_ADDRESS, "stall_done");

        // Full stall with full and pkt_valid low together, exit via parity_done
        startPacket(2'd0);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        applyStimulus(FIFO_FULL_STATE, "fullwins");
        fifo_full = 1'b0;
        applyStimulus(LOAD_AFTER_FULL, "pd_laf");
        parity_done = 1'b1;
        applyStimulus(DECODE_ADDRESS, "pd_done");
        parity_done = 1'b0;

        // LAF with neither flag returns to LOAD_DATA; CHECK_PARITY with full re-stalls
        startPacket(2'd2);
        fifo_full = 1'b1;
        applyStimulus(FIFO_FULL_STATE, "laf_full");
        fifo_full = 1'b0;
        applyStimulus(LOAD_AFTER_FULL, "laf_laf");
        applyStimulus(LOAD_DATA, "laf_back_ld");
        pkt_valid = 1'b0;
        applyStimulus(LOAD_PARITY, "cpe_lp");
        fifo_full = 1'b1;
        applyStimulus(CHECK_PARITY_ERROR, "cpe_cpe");
        applyStimulus(FIFO_FULL_STATE, "cpe_full");
        fifo_full = 1'b0;
        applyStimulus(LOAD_AFTER_FULL, "cpe_laf");
        parity_done = 1'b1;
        applyStimulus(DECODE_ADDRESS, "cpe_done");
        parity_done = 1'b0;

        // Busy destination on port 2
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(WAIT_TILL_EMPTY, "wait_busy");
        fifo_empty_2 = 1'b1; data_in = 2'd0;
        applyStimulus(LOAD_FIRST_DATA, "wait_lfd");
        pkt_valid = 1'b0;
        applyStimulus(LOAD_DATA, "wait_ld");
        applyStimulus(LOAD_PARITY, "wait_lp");
        applyStimulus(CHECK_PARITY_ERROR, "wait_cpe");
        applyStimulus(DECODE_ADDRESS, "wait_done");

        // Soft abort on the addressed port only
        startPacket(2'd1);
        fifo_full = 1'b1;
        applyStimulus(FIFO_FULL_STATE, "sr_full");
        soft_reset_0 = 1'b1;
        applyStimulus(FIFO_FULL_STATE, "sr_other_ignored");
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
        exp_drop = exp_drop + 8'd1;
        applyStimulus(DECODE_ADDRESS, "sr_abort");
        fifo_full = 1'b0; pkt_valid = 1'b1; data_in = 2'd0;
        applyStimulus(DECODE_ADDRESS, "sr_priority");
        applyStimulus(LOAD_FIRST_DATA, "sr_newaddr");
        soft_reset_1 = 1'b0; pkt_valid = 1'b0;
        applyStimulus(LOAD_DATA, "sr_ld");
        applyStimulus(LOAD_PARITY, "sr_lp");
        applyStimulus(CHECK_PARITY_ERROR, "sr_cpe");
        applyStimulus(DECODE_ADDRESS, "sr_done");

        // Invalid address stays in decode
        pkt_valid = 1'b1; data_in = 2'd3;
        applyStimulus(DECODE_ADDRESS, "inv0");
        applyStimulus(DECODE_ADDRESS, "inv1");

`ifdef ROUTER_FSM_DROP_CNT_EN
        // Drive the abort counter into saturation
        for (int i = 0; i < 260; i++) begin
            pkt_valid = 1'b1; data_in = 2'd2;
            applyStimulus(LOAD_FIRST_DATA, "sat_lfd");
            pkt_valid = 1'b0; soft_reset_2 = 1'b1;
            if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
            applyStimulus(DECODE_ADDRESS, "sat_abort");
            soft_reset_2 = 1'b0;
        end
`endif

        // Reset in the middle of a packet
        startPacket(2'd0);
        resetn = 1'b0; exp_drop = 8'd0;
        applyStimulus(DECODE_ADDRESS, "rst_mid");
        resetn = 1'b1; pkt_valid = 1'b0;
        applyStimulus(DECODE_ADDRESS, "rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
